// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the memory-access pipeline stage.
// The optional access watchdog is enabled by defining MEM_TIMEOUT_EN.
package mem_stage_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DATA_W_DEF         = 32;
  localparam int REG_W_DEF          = 5;
  localparam int TIMEOUT_CYCLES_DEF = 16;

endpackage

// File: rtl/mem_watchdog.sv
// Access watchdog: counts ACCESS cycles without ack and flags the cycle in
// which the count would reach TIMEOUT_CYCLES. Only instantiated when
// MEM_TIMEOUT_EN is defined.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles; clearing takes priority so a fresh access starts at 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Expire on the enabled cycle whose increment would land on TIMEOUT_CYCLES
  always_comb begin
    expire = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: latches Execute results, runs the data-memory
// req/ack transaction, resolves the branch and emits a one-cycle writeback
// bundle. Define MEM_TIMEOUT_EN to abort accesses that never get an ack.
//
// state  | meaning
// IDLE   | ready to accept an op; non-memory ops write back straight away
// ACCESS | memory request outstanding, upstream stalled
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int REG_W          = REG_W_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iin_valid,
  input  logic              iSig_MemRead,
  input  logic              iSig_MemWrite,
  input  logic              iSig_Branch,
  input  logic              iSig_RegWrite,
  input  logic              iSig_MemtoReg,
  input  logic [DATA_W-1:0] iadder_branch_result,
  input  logic              iALU_zero,
  input  logic [DATA_W-1:0] iALU_result,
  input  logic [DATA_W-1:0] iregfile_read_2,
  input  logic [REG_W-1:0]  ireg_write_reg,
  output logic              ostall,
  output logic              omem_req,
  output logic              omem_we,
  output logic [DATA_W-1:0] omem_addr,
  output logic [DATA_W-1:0] omem_wdata,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              oPCSrc,
  output logic [DATA_W-1:0] obranch_target,
  output logic              owb_valid,
  output logic              owb_RegWrite,
  output logic              owb_MemtoReg,
  output logic [DATA_W-1:0] owb_read_data,
  output logic [DATA_W-1:0] owb_alu_result,
  output logic [REG_W-1:0]  owb_write_reg,
  output logic              oerr_timeout
);

  // A zero timeout would make the watchdog compare against -1
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_access_stage: TIMEOUT_CYCLES must be at least 1");
  end

  state_t             state;
  logic               lat_regwrite;
  logic               lat_memtoreg;
  logic               lat_taken;
  logic [DATA_W-1:0]  lat_target;
  logic [REG_W-1:0]   lat_write_reg;

  logic               accept;
  logic               accept_mem;
  logic               ack_hit;
  logic               tmo_expire;

  // Handshake decode; an ack only counts while a request is outstanding
  always_comb begin
    accept     = (state == IDLE) && iin_valid;
    accept_mem = accept && (iSig_MemRead || iSig_MemWrite);
    ack_hit    = omem_req && imem_ack;
  end

  // Stall comes straight from the state register
  always_comb begin
    ostall = (state == ACCESS);
  end

`ifdef MEM_TIMEOUT_EN
  logic err_q;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (accept_mem),
    .enable ((state == ACCESS) && !imem_ack),
    .expire (tmo_expire)
  );

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (tmo_expire && !ack_hit) begin
      err_q <= 1'b1;
    end
  end

  assign oerr_timeout = err_q;
`else
  assign tmo_expire   = 1'b0;
  assign oerr_timeout = 1'b0;
`endif

  // Stage FSM: accept, memory transaction and writeback bundle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      omem_req       <= 1'b0;
      omem_we        <= 1'b0;
      omem_addr      <= '0;
      omem_wdata     <= '0;
      oPCSrc         <= 1'b0;
      obranch_target <= '0;
      owb_valid      <= 1'b0;
      owb_RegWrite   <= 1'b0;
      owb_MemtoReg   <= 1'b0;
      owb_read_data  <= '0;
      owb_alu_result <= '0;
      owb_write_reg  <= '0;
      lat_regwrite   <= 1'b0;
      lat_memtoreg   <= 1'b0;
      lat_taken      <= 1'b0;
      lat_target     <= '0;
      lat_write_reg  <= '0;
    end else begin
      owb_valid <= 1'b0;
      oPCSrc    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_mem) begin
            // omem_addr doubles as the held ALU result for memory ops
            state         <= ACCESS;
            omem_req      <= 1'b1;
            omem_we       <= iSig_MemWrite;
            omem_addr     <= iALU_result;
            omem_wdata    <= iregfile_read_2;
            lat_regwrite  <= iSig_RegWrite;
            lat_memtoreg  <= iSig_MemtoReg;
            lat_taken     <= iSig_Branch && iALU_zero;
            lat_target    <= iadder_branch_result;
            lat_write_reg <= ireg_write_reg;
          end else if (accept) begin
            owb_valid      <= 1'b1;
            oPCSrc         <= iSig_Branch && iALU_zero;
            obranch_target <= iadder_branch_result;
            owb_RegWrite   <= iSig_RegWrite;
            owb_MemtoReg   <= iSig_MemtoReg;
            owb_read_data  <= '0;
            owb_alu_result <= iALU_result;
            owb_write_reg  <= ireg_write_reg;
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            state          <= IDLE;
            omem_req       <= 1'b0;
            owb_valid      <= 1'b1;
            oPCSrc         <= lat_taken;
            obranch_target <= lat_target;
            owb_RegWrite   <= lat_regwrite;
            owb_MemtoReg   <= lat_memtoreg;
            owb_read_data  <= omem_we ? '0 : imem_rdata;
            owb_alu_result <= omem_addr;
            owb_write_reg  <= lat_write_reg;
          end else if (tmo_expire) begin
            // Aborted access: retire the op without a register write or branch
            state          <= IDLE;
            omem_req       <= 1'b0;
            owb_valid      <= 1'b1;
            obranch_target <= lat_target;
            owb_RegWrite   <= 1'b0;
            owb_MemtoReg   <= lat_memtoreg;
            owb_read_data  <= '0;
            owb_alu_result <= omem_addr;
            owb_write_reg  <= lat_write_reg;
          end
        end
        default: begin
          state    <= IDLE;
          omem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage (timeout section active with MEM_TIMEOUT_EN).
module tb_mem_access_stage;

  logic        clk;
  logic        rstn;
  logic        iin_valid;
  logic        iSig_MemRead, iSig_MemWrite, iSig_Branch, iSig_RegWrite, iSig_MemtoReg;
  logic [31:0] iadder_branch_result;
  logic        iALU_zero;
  logic [31:0] iALU_result;
  logic [31:0] iregfile_read_2;
  logic [4:0]  ireg_write_reg;
  logic        ostall, omem_req, omem_we;
  logic [31:0] omem_addr, omem_wdata;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        oPCSrc;
  logic [31:0] obranch_target;
  logic        owb_valid, owb_RegWrite, owb_MemtoReg;
  logic [31:0] owb_read_data, owb_alu_result;
  logic [4:0]  owb_write_reg;
  logic        oerr_timeout;

  int n_checks = 0;
  int n_pass   = 0;
  int wb_pulses = 0;
  int wb_base;

  mem_access_stage #(
    .DATA_W(32),
    .REG_W(5)
`ifdef MEM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(4)
`endif
  ) dut (
    .clk(clk), .rstn(rstn), .iin_valid(iin_valid),
    .iSig_MemRead(iSig_MemRead), .iSig_MemWrite(iSig_MemWrite),
    .iSig_Branch(iSig_Branch), .iSig_RegWrite(iSig_RegWrite),
    .iSig_MemtoReg(iSig_MemtoReg),
    .iadder_branch_result(iadder_branch_result), .iALU_zero(iALU_zero),
    .iALU_result(iALU_result), .iregfile_read_2(iregfile_read_2),
    .ireg_write_reg(ireg_write_reg),
    .ostall(ostall), .omem_req(omem_req), .omem_we(omem_we),
    .omem_addr(omem_addr), .omem_wdata(omem_wdata),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .oPCSrc(oPCSrc), .obranch_target(obranch_target),
    .owb_valid(owb_valid), .owb_RegWrite(owb_RegWrite),
    .owb_MemtoReg(owb_MemtoReg), .owb_read_data(owb_read_data),
    .owb_alu_result(owb_alu_result), .owb_write_reg(owb_write_reg),
    .oerr_timeout(oerr_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (owb_valid) wb_pulses++;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    iin_valid = 0; iSig_MemRead = 0; iSig_MemWrite = 0; iSig_Branch = 0;
    iSig_RegWrite = 0; iSig_MemtoReg = 0; iadder_branch_result = 0;
    iALU_zero = 0; iALU_result = 0; iregfile_read_2 = 0; ireg_write_reg = 0;
  endtask

  initial begin
    rstn = 0; imem_ack = 0; imem_rdata = 0;
    clear_in();
    #2;
    check_eq("rst_stall", ostall, 0);
    check_eq("rst_req", omem_req, 0);
    check_eq("rst_wb_valid", owb_valid, 0);
    check_eq("rst_pcsrc", oPCSrc, 0);
    check_eq("rst_alu", owb_alu_result, 0);
    check_eq("rst_err", oerr_timeout, 0);
    step(); step();
    rstn = 1;
    step();

    // ALU op
    iin_valid = 1; iALU_result = 32'h2A; ireg_write_reg = 5; iSig_RegWrite = 1;
    step();
    clear_in();
    check_eq("alu_wb_valid", owb_valid, 1);
    check_eq("alu_result", owb_alu_result, 32'h2A);
    check_eq("alu_wreg", owb_write_reg, 5);
    check_eq("alu_regwrite", owb_RegWrite, 1);
    check_eq("alu_rdata", owb_read_data, 0);
    check_eq("alu_stall", ostall, 0);
    step();
    check_eq("alu_wb_pulse_end", owb_valid, 0);
    check_eq("alu_hold", owb_alu_result, 32'h2A);

    // Load, ack in third ACCESS cycle
    iin_valid = 1; iSig_MemRead = 1; iSig_MemtoReg = 1; iSig_RegWrite = 1;
    iALU_result = 32'h100; ireg_write_reg = 7;
    step();
    clear_in();
    check_eq("ld_req", omem_req, 1);
    check_eq("ld_we", omem_we, 0);
    check_eq("ld_addr", omem_addr, 32'h100);
    check_eq("ld_stall1", ostall, 1);
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq("ld_stall_n", ostall, 1);
      check_eq("ld_addr_stable", omem_addr, 32'h100);
      check_eq("ld_no_wb", owb_valid, 0);
    end
    imem_ack = 1; imem_rdata = 32'hDEADBEEF;
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("ld_req_drop", omem_req, 0);
    check_eq("ld_stall_drop", ostall, 0);
    check_eq("ld_wb_valid", owb_valid, 1);
    check_eq("ld_rdata", owb_read_data, 32'hDEADBEEF);
    check_eq("ld_memtoreg", owb_MemtoReg, 1);
    check_eq("ld_wreg", owb_write_reg, 7);
    check_eq("ld_alu", owb_alu_result, 32'h100);
    imem_ack = 1; imem_rdata = 32'h12345678;
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("stray_ack_wb", owb_valid, 0);
    check_eq("stray_ack_hold", owb_read_data, 32'hDEADBEEF);

    // Store with second op waiting during the stall
    wb_base = wb_pulses;
    iin_valid = 1; iSig_MemWrite = 1; iALU_result = 32'h104; iregfile_read_2 = 32'h55AA;
    step();
    clear_in();
    check_eq("st_we", omem_we, 1);
    check_eq("st_wdata", omem_wdata, 32'h55AA);
    check_eq("st_addr", omem_addr, 32'h104);
    iin_valid = 1; iALU_result = 32'h77; ireg_write_reg = 3; iSig_RegWrite = 1;
    step();
    check_eq("st_stall", ostall, 1);
    check_eq("st_wdata_hold", omem_wdata, 32'h55AA);
    check_eq("st_no_wb", owb_valid, 0);
    imem_ack = 1; imem_rdata = 32'hFFFF0000;
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("st_wb_valid", owb_valid, 1);
    check_eq("st_regwrite", owb_RegWrite, 0);
    check_eq("st_rdata", owb_read_data, 0);
    check_eq("st_alu", owb_alu_result, 32'h104);
    step();
    clear_in();
    check_eq("op2_wb_valid", owb_valid, 1);
    check_eq("op2_alu", owb_alu_result, 32'h77);
    check_eq("op2_wreg", owb_write_reg, 3);
    step();
    check_eq("st_idle_wb", owb_valid, 0);
    check_eq("st_two_pulses", wb_pulses - wb_base, 2);

    // Read and write both set behaves as a write
    iin_valid = 1; iSig_MemRead = 1; iSig_MemWrite = 1; iALU_result = 32'h200;
    step();
    clear_in();
    check_eq("rw_we", omem_we, 1);
    imem_ack = 1; imem_rdata = 32'h1234;
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("rw_wb_valid", owb_valid, 1);
    check_eq("rw_rdata", owb_read_data, 0);

    // Branch taken / not taken
    iin_valid = 1; iSig_Branch = 1; iALU_zero = 1; iadder_branch_result = 32'h400;
    step();
    clear_in();
    check_eq("br_pcsrc", oPCSrc, 1);
    check_eq("br_target", obranch_target, 32'h400);
    step();
    check_eq("br_pulse_end", oPCSrc, 0);
    iin_valid = 1; iSig_Branch = 1; iALU_zero = 0; iadder_branch_result = 32'h440;
    step();
    clear_in();
    check_eq("brnt_pcsrc", oPCSrc, 0);
    check_eq("brnt_wb", owb_valid, 1);

    // Branch on a memory op pulses with the writeback
    iin_valid = 1; iSig_MemRead = 1; iSig_Branch = 1; iALU_zero = 1;
    iadder_branch_result = 32'h800; iALU_result = 32'h20;
    step();
    clear_in();
    check_eq("brm_early", oPCSrc, 0);
    imem_ack = 1; imem_rdata = 32'hA5;
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("brm_pcsrc", oPCSrc, 1);
    check_eq("brm_wb", owb_valid, 1);
    check_eq("brm_target", obranch_target, 32'h800);

    // Reset in the middle of an access
    iin_valid = 1; iSig_MemRead = 1; iSig_RegWrite = 1; iALU_result = 32'h300;
    step();
    clear_in();
    check_eq("rm_req", omem_req, 1);
    #2 rstn = 0;
    #1;
    check_eq("rm_req_drop", omem_req, 0);
    check_eq("rm_stall", ostall, 0);
    step();
    rstn = 1; imem_ack = 1; imem_rdata = 32'hBAD;
    step();
    check_eq("rm_no_wb", owb_valid, 0);
    step();
    imem_ack = 0; imem_rdata = 0;
    check_eq("rm_no_wb2", owb_valid, 0);
    check_eq("rm_idle", ostall, 0);

`ifdef MEM_TIMEOUT_EN
    iin_valid = 1; iSig_MemRead = 1; iSig_RegWrite = 1; iALU_result = 32'h500;
    step();
    clear_in();
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("to_req_held", omem_req, 1);
    end
    step();
    check_eq("to_req_drop", omem_req, 0);
    check_eq("to_wb", owb_valid, 1);
    check_eq("to_regwrite", owb_RegWrite, 0);
    check_eq("to_err", oerr_timeout, 1);
    step(); step();
    check_eq("to_err_sticky", oerr_timeout, 1);
`else
    check_eq("no_tmo_err", oerr_timeout, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Consumer side of the Execute stage outputs: registers the ALU result, zero flag, branch target, store data and destination register.
- Performs the data-memory transaction over a req/ack port, resolves the branch decision and presents a one-cycle writeback bundle to the register-file writeback logic.
- Stalls upstream while a memory access is outstanding.

Parameters:
- DATA_W, 32, datapath and address width.
- REG_W, 5, destination-register index width.
- TIMEOUT_CYCLES, 16, cycles in ACCESS before abort; used only with the optional feature.

Ports:
- clk  in  1  clock, rising-edge.
- rstn  in  1  reset; asynchronous and active-low.
- iin_valid  in  1  Execute outputs valid this cycle.
- iSig_MemRead / iSig_MemWrite / iSig_Branch / iSig_RegWrite / iSig_MemtoReg  in  1 each  control bits of the op.
- iadder_branch_result  in  DATA_W  branch target.
- iALU_zero  in  1  ALU zero flag.
- iALU_result  in  DATA_W  ALU result / memory address.
- iregfile_read_2  in  DATA_W  store data.
- ireg_write_reg  in  REG_W  destination register.
- ostall  out  1  upstream must hold its outputs.
- omem_req  out  1  memory request.
- omem_we  out  1  1 = write.
- omem_addr  out  DATA_W  address.
- omem_wdata  out  DATA_W  write data.
- imem_ack  in  1  request completed.
- imem_rdata  in  DATA_W  read data, valid with imem_ack.
- oPCSrc  out  1  take branch, one-cycle pulse.
- obranch_target  out  DATA_W  registered branch target.
- owb_valid  out  1  writeback bundle valid, one-cycle pulse.
- owb_RegWrite / owb_MemtoReg  out  1 each  registered control bits.
- owb_read_data  out  DATA_W  memory read data.
- owb_alu_result  out  DATA_W  registered ALU result.
- owb_write_reg  out  REG_W  destination register.
- oerr_timeout  out  1  sticky timeout flag.

Behaviour:
- Reset: every output and all internal registers go to 0 asynchronously; state = IDLE. Reset during ACCESS drops omem_req immediately; the in-flight op is discarded with no writeback.
- States: IDLE, ACCESS. ostall = (state == ACCESS), driven from the state register only.
- Accept: iin_valid=1 in IDLE. All inputs are latched at that edge.
- iin_valid during ACCESS is ignored; upstream holds because ostall=1.
- Non-memory op (MemRead=MemWrite=0): the cycle after accept, owb_valid=1 with the latched fields, owb_read_data=0, and oPCSrc=iSig_Branch&iALU_zero. State stays IDLE, so back-to-back accepts give one writeback per cycle.
- Memory op: next state = ACCESS. omem_req=1 from the cycle after accept. omem_we, omem_addr and omem_wdata stay stable until ack.
- MemWrite and MemRead both set: treated as a write; owb_read_data=0.
- imem_ack is sampled only while omem_req=1; an ack outside ACCESS is ignored.
- On ack: omem_req drops next cycle, state goes to IDLE, imem_rdata is captured (reads only). owb_valid pulses in the same cycle that omem_req drops.
- Minimum latency for a memory op is 2 cycles, accept to owb_valid (ack in the first ACCESS cycle).
- Branch on a memory op: oPCSrc pulses together with owb_valid.
- owb_* fields other than owb_valid hold their values until the next writeback. oPCSrc and owb_valid are 0 in all other cycles.
- A new op may be accepted in the same cycle owb_valid pulses (state is IDLE).

Optional Feature:
- Macro MEM_TIMEOUT_EN.
- With it: a counter clears on entry to ACCESS and increments each ACCESS cycle without ack. When the count reaches TIMEOUT_CYCLES:
  - omem_req drops and state returns to IDLE;
  - owb_valid pulses with owb_RegWrite forced to 0;
  - oerr_timeout is set and stays 1 until reset.
- An ack in the same cycle the count reaches TIMEOUT_CYCLES wins over the timeout.
- Without it: the block waits for ack indefinitely and oerr_timeout is tied to 0.

Decomposition:
- Package mem_stage_pkg holds the state enum {IDLE, ACCESS}, the DATA_W/REG_W defaults and the TIMEOUT_CYCLES default.
- One sub-module, mem_watchdog: the timeout counter with clear/enable/expire. It is instantiated only under MEM_TIMEOUT_EN.

Test Plan:
- ALU op: iALU_result=0x2A, reg 5, RegWrite=1, no mem -> next cycle owb_valid=1, owb_alu_result=0x2A, owb_write_reg=5, ostall=0.
- Load: addr 0x100, ack 3 cycles after omem_req rises, rdata=0xDEADBEEF -> ostall=1 for 3 cycles, omem_we=0, addr stable, owb_read_data=0xDEADBEEF, owb_MemtoReg=1.
- Store: addr 0x104, wdata 0x55AA; second op presented during stall -> omem_we=1, wdata 0x55AA held, second op accepted only after return to IDLE, exactly two owb_valid pulses.
- Branch: iSig_Branch=1, zero=1, target 0x400 -> oPCSrc pulse with obranch_target=0x400. With zero=0 -> oPCSrc stays 0.
- Reset asserted mid-ACCESS -> omem_req=0 immediately, no owb_valid after reset release, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> omem_req drops after 4 ACCESS cycles, owb_valid=1 with RegWrite=0, oerr_timeout stays 1.
